// File: rtl/regbank_arb_pkg.sv
// ----------------------------------------------------------------------------
// regbank_arb_pkg
// Shared types and constants for the register-bank port arbiter.
//   owner_e  : who an in-flight read belongs to
//   rr_e     : round-robin pointer between decode and debug
//   tag_t    : per-slot return tag (owner plus per-source x0 flags)
//   GNT_*    : bit positions of the one-hot grant vector
// ----------------------------------------------------------------------------
package regbank_arb_pkg;

    localparam int         XLEN_DEF = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int GNT_WB  = 0;
    localparam int GNT_RD  = 1;
    localparam int GNT_DBG = 2;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_RD,
        OWN_DBG
    } owner_e;

    typedef enum logic {
        RR_RD  = 1'b0,
        RR_DBG = 1'b1
    } rr_e;

    // zero0/zero1 mark sources that selected x0 and must read back as 0.
    typedef struct packed {
        owner_e owner;
        logic   zero0;
        logic   zero1;
    } tag_t;

    localparam tag_t TAG_NONE = '{owner: OWN_NONE, zero0: 1'b0, zero1: 1'b0};

endpackage

// File: rtl/regbank_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// regbank_port_arbiter_if
// Bundles the three requester handshakes and the bank-side command/data bus.
//   slave  : the arbiter (takes requests and bank read data, drives acks,
//            return data and the bank command)
//   master : the environment (requesters plus the register bank)
// ----------------------------------------------------------------------------
interface regbank_port_arbiter_if
    import regbank_arb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    // writeback
    logic            wbReq;
    logic [4:0]      wbSel;
    logic [XLEN-1:0] wbData;
    logic            wbAck;
    // decode
    logic            rdReq;
    logic [4:0]      rdSel0;
    logic [4:0]      rdSel1;
    logic            rdAck;
    logic            rdValid;
    logic [XLEN-1:0] rdData0;
    logic [XLEN-1:0] rdData1;
    // debug
    logic            dbgReq;
    logic            dbgRDWRBar;
    logic [4:0]      dbgSel;
    logic [XLEN-1:0] dbgWData;
    logic            dbgAck;
    logic            dbgValid;
    logic [XLEN-1:0] dbgRData;
    // bank
    logic            bankCSBar;
    logic            bankRDWRBar;
    logic [4:0]      bankSelSrc0;
    logic [4:0]      bankSelSrc1;
    logic [4:0]      bankSelDst;
    logic [XLEN-1:0] bankDst;
    logic [XLEN-1:0] bankSrc0;
    logic [XLEN-1:0] bankSrc1;

    modport slave (
        input  wbReq, wbSel, wbData,
        input  rdReq, rdSel0, rdSel1,
        input  dbgReq, dbgRDWRBar, dbgSel, dbgWData,
        input  bankSrc0, bankSrc1,
        output wbAck, rdAck, rdValid, rdData0, rdData1,
        output dbgAck, dbgValid, dbgRData,
        output bankCSBar, bankRDWRBar, bankSelSrc0, bankSelSrc1, bankSelDst, bankDst
    );

    modport master (
        output wbReq, wbSel, wbData,
        output rdReq, rdSel0, rdSel1,
        output dbgReq, dbgRDWRBar, dbgSel, dbgWData,
        output bankSrc0, bankSrc1,
        input  wbAck, rdAck, rdValid, rdData0, rdData1,
        input  dbgAck, dbgValid, dbgRData,
        input  bankCSBar, bankRDWRBar, bankSelSrc0, bankSelSrc1, bankSelDst, bankDst
    );

endinterface

// File: rtl/rr_starve_arbiter.sv
// ----------------------------------------------------------------------------
// rr_starve_arbiter
// Picks at most one of writeback/decode/debug each cycle.
//   clk, resetBar      : clock, async active-low reset
//   wb_req_i           : writeback request
//   rd_req_i           : decode request
//   dbg_req_i          : debug request
//   gnt_o[2:0]         : one-hot grant, indexed by GNT_WB/GNT_RD/GNT_DBG
// Order: starved decode/debug, then writeback, then decode/debug round-robin.
// ----------------------------------------------------------------------------
module rr_starve_arbiter
    import regbank_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       resetBar,
    input  logic       wb_req_i,
    input  logic       rd_req_i,
    input  logic       dbg_req_i,
    output logic [2:0] gnt_o
);

    localparam int            CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] rd_cnt_q,  rd_cnt_d;
    logic [CW-1:0] dbg_cnt_q, dbg_cnt_d;
    rr_e           ptr_q,     ptr_d;
    logic          rd_starved, dbg_starved;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
        return (cnt == LIMIT) ? cnt : cnt + 1'b1;
    endfunction

    always_comb begin
        // NOTE: every output gets a default before the if-chain so no path
        // leaves it unassigned and no latch is inferred.
        gnt_o       = '0;
        rd_starved  = rd_req_i  && (rd_cnt_q  == LIMIT);
        dbg_starved = dbg_req_i && (dbg_cnt_q == LIMIT);

        if (rd_starved && dbg_starved) begin
            if (ptr_q == RR_RD) gnt_o[GNT_RD]  = 1'b1;
            else                gnt_o[GNT_DBG] = 1'b1;
        end else if (rd_starved) begin
            gnt_o[GNT_RD] = 1'b1;
        end else if (dbg_starved) begin
            gnt_o[GNT_DBG] = 1'b1;
        end else if (wb_req_i) begin
            gnt_o[GNT_WB] = 1'b1;
        end else if (rd_req_i && dbg_req_i) begin
            if (ptr_q == RR_RD) gnt_o[GNT_RD]  = 1'b1;
            else                gnt_o[GNT_DBG] = 1'b1;
        end else if (rd_req_i) begin
            gnt_o[GNT_RD] = 1'b1;
        end else if (dbg_req_i) begin
            gnt_o[GNT_DBG] = 1'b1;
        end
    end

    // A counter only grows while its request waits; any ack or idle clears it.
    always_comb begin
        rd_cnt_d  = (rd_req_i  && !gnt_o[GNT_RD])  ? sat_inc(rd_cnt_q)  : '0;
        dbg_cnt_d = (dbg_req_i && !gnt_o[GNT_DBG]) ? sat_inc(dbg_cnt_q) : '0;
        ptr_d     = ptr_q;
        if (gnt_o[GNT_RD])  ptr_d = RR_DBG;
        if (gnt_o[GNT_DBG]) ptr_d = RR_RD;
    end

    always_ff @(posedge clk or negedge resetBar) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!resetBar) begin
            rd_cnt_q  <= '0;
            dbg_cnt_q <= '0;
            ptr_q     <= RR_RD;
        end else begin
            rd_cnt_q  <= rd_cnt_d;
            dbg_cnt_q <= dbg_cnt_d;
            ptr_q     <= ptr_d;
        end
    end

endmodule

// File: rtl/regbank_port_arbiter.sv
// ----------------------------------------------------------------------------
// regbank_port_arbiter
// Shares a single-command 32x32 register bank between writeback, decode
// (dual read) and debug (single read/write).
//   clk, resetBar : clock, async active-low reset
//   bus (slave)   : requester handshakes, return data and bank command bus
// Grant in N -> command on bank during N+1 -> bank outputs valid in N+2,
// where the owner tag (carried alongside) raises rdValid or dbgValid.
// ----------------------------------------------------------------------------
module regbank_port_arbiter
    import regbank_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = XLEN_DEF
) (
    input  logic                  clk,
    input  logic                  resetBar,
    regbank_port_arbiter_if.slave bus
);

    logic [2:0] gnt;

    rr_starve_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
        .clk       (clk),
        .resetBar  (resetBar),
        .wb_req_i  (bus.wbReq),
        .rd_req_i  (bus.rdReq),
        .dbg_req_i (bus.dbgReq),
        .gnt_o     (gnt)
    );

    assign bus.wbAck  = gnt[GNT_WB];
    assign bus.rdAck  = gnt[GNT_RD];
    assign bus.dbgAck = gnt[GNT_DBG];

    // Issue stage
    logic            cs_bar_q,   cs_bar_d;
    logic            rdwr_bar_q, rdwr_bar_d;
    logic [4:0]      sel0_q,     sel0_d;
    logic [4:0]      sel1_q,     sel1_d;
    logic [4:0]      dst_q,      dst_d;
    logic [XLEN-1:0] wdata_q,    wdata_d;
    tag_t            tag1_q,     tag1_d;
    // Return stage
    tag_t            tag2_q;
    logic [XLEN-1:0] rd0_q, rd0_d, rd1_q, rd1_d, dbg_q, dbg_d;
    logic            rd_valid, dbg_valid;

    always_comb begin
        cs_bar_d   = 1'b1;
        rdwr_bar_d = 1'b1;
        sel0_d     = sel0_q;
        sel1_d     = sel1_q;
        dst_d      = dst_q;
        wdata_d    = wdata_q;
        tag1_d     = TAG_NONE;

        // Writes to x0 are acked but never reach the bank.
        if (gnt[GNT_WB]) begin
            cs_bar_d   = (bus.wbSel == REG_ZERO);
            rdwr_bar_d = 1'b0;
            dst_d      = bus.wbSel;
            wdata_d    = bus.wbData;
        end else if (gnt[GNT_RD]) begin
            cs_bar_d   = 1'b0;
            sel0_d     = bus.rdSel0;
            sel1_d     = bus.rdSel1;
            tag1_d     = '{owner: OWN_RD,
                           zero0: (bus.rdSel0 == REG_ZERO),
                           zero1: (bus.rdSel1 == REG_ZERO)};
        end else if (gnt[GNT_DBG]) begin
            if (bus.dbgRDWRBar) begin
                cs_bar_d = 1'b0;
                sel0_d   = bus.dbgSel;
                sel1_d   = REG_ZERO;
                tag1_d   = '{owner: OWN_DBG,
                             zero0: (bus.dbgSel == REG_ZERO),
                             zero1: 1'b0};
            end else begin
                cs_bar_d   = (bus.dbgSel == REG_ZERO);
                rdwr_bar_d = 1'b0;
                dst_d      = bus.dbgSel;
                wdata_d    = bus.dbgWData;
            end
        end
    end

    // Return data is passed straight from the bank in the valid cycle and held
    // in a register afterwards, so outputs keep their last value when idle.
    always_comb begin
        rd_valid  = (tag2_q.owner == OWN_RD);
        dbg_valid = (tag2_q.owner == OWN_DBG);
        rd0_d     = rd0_q;
        rd1_d     = rd1_q;
        dbg_d     = dbg_q;
        if (rd_valid) begin
            rd0_d = tag2_q.zero0 ? '0 : bus.bankSrc0;
            rd1_d = tag2_q.zero1 ? '0 : bus.bankSrc1;
        end
        if (dbg_valid) begin
            dbg_d = tag2_q.zero0 ? '0 : bus.bankSrc0;
        end
    end

    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            cs_bar_q   <= 1'b1;
            rdwr_bar_q <= 1'b1;
            sel0_q     <= '0;
            sel1_q     <= '0;
            dst_q      <= '0;
            wdata_q    <= '0;
            tag1_q     <= TAG_NONE;
            tag2_q     <= TAG_NONE;
            rd0_q      <= '0;
            rd1_q      <= '0;
            dbg_q      <= '0;
        end else begin
            cs_bar_q   <= cs_bar_d;
            rdwr_bar_q <= rdwr_bar_d;
            sel0_q     <= sel0_d;
            sel1_q     <= sel1_d;
            dst_q      <= dst_d;
            wdata_q    <= wdata_d;
            tag1_q     <= tag1_d;
            tag2_q     <= tag1_q;
            rd0_q      <= rd0_d;
            rd1_q      <= rd1_d;
            dbg_q      <= dbg_d;
        end
    end

    assign bus.bankCSBar   = cs_bar_q;
    assign bus.bankRDWRBar = rdwr_bar_q;
    assign bus.bankSelSrc0 = sel0_q;
    assign bus.bankSelSrc1 = sel1_q;
    assign bus.bankSelDst  = dst_q;
    assign bus.bankDst     = wdata_q;
    assign bus.rdValid     = rd_valid;
    assign bus.rdData0     = rd0_d;
    assign bus.rdData1     = rd1_d;
    assign bus.dbgValid    = dbg_valid;
    assign bus.dbgRData    = dbg_d;

endmodule

// File: tb/tb_regbank_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regbank_port_arbiter
// Directed bench for regbank_port_arbiter with a behavioural register bank.
// Stimulus pushes hand-computed read results (with their due cycle) into
// queues; a negedge monitor pops and compares whenever a valid is raised.
// ----------------------------------------------------------------------------
module tb_regbank_port_arbiter;
    import regbank_arb_pkg::*;

    localparam int XLEN = 32;

    logic clk      = 1'b0;
    logic resetBar = 1'b0;
    always #5 clk = ~clk;

    regbank_port_arbiter_if #(.XLEN(XLEN)) bus ();

    regbank_port_arbiter #(.STARVE_LIMIT(4), .XLEN(XLEN)) dut (
        .clk      (clk),
        .resetBar (resetBar),
        .bus      (bus)
    );

    // Behavioural bank: unwritten registers read as 0xBAD0_00nn.
    logic [31:0] mem [32];
    logic [31:0] written = '0;

    function automatic logic [31:0] bank_rd(input logic [4:0] s);
        return written[s] ? mem[s] : (32'hBAD0_0000 | 32'(s));
    endfunction

    always @(posedge clk) begin
        if (!bus.bankCSBar) begin
            if (!bus.bankRDWRBar) begin
                mem[bus.bankSelDst]     <= bus.bankDst;
                written[bus.bankSelDst] <= 1'b1;
            end else begin
                bus.bankSrc0 <= bank_rd(bus.bankSelSrc0);
                bus.bankSrc1 <= bank_rd(bus.bankSelSrc1);
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        int          due;
    } rd_exp_t;

    typedef struct {
        logic [31:0] d;
        int          due;
    } dbg_exp_t;

    rd_exp_t  rd_q  [$];
    dbg_exp_t dbg_q [$];
    rd_exp_t  re;
    dbg_exp_t de;

    // Monitor
    always @(negedge clk) begin
        if (resetBar) begin
            if (bus.rdValid) begin
                if (rd_q.size() == 0) begin
                    check("rd_valid_unexpected", bus.rdValid, 1'b0);
                end else begin
                    re = rd_q.pop_front();
                    check("rd_latency", cyc, re.due);
                    check("rd_data0", bus.rdData0, re.d0);
                    check("rd_data1", bus.rdData1, re.d1);
                end
            end
            if (bus.dbgValid) begin
                if (dbg_q.size() == 0) begin
                    check("dbg_valid_unexpected", bus.dbgValid, 1'b0);
                end else begin
                    de = dbg_q.pop_front();
                    check("dbg_latency", cyc, de.due);
                    check("dbg_rdata", bus.dbgRData, de.d);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_rd(input logic [31:0] d0, input logic [31:0] d1);
        rd_q.push_back('{d0: d0, d1: d1, due: cyc + 2});
    endtask

    task automatic push_dbg(input logic [31:0] d);
        dbg_q.push_back('{d: d, due: cyc + 2});
    endtask

    task automatic do_wb(input logic [4:0] sel, input logic [31:0] data);
        bus.wbReq = 1'b1; bus.wbSel = sel; bus.wbData = data;
        @(negedge clk);
        check("wb_ack", bus.wbAck, 1'b1);
        step();
        bus.wbReq = 1'b0;
    endtask

    task automatic do_rd(input logic [4:0] s0, input logic [4:0] s1,
                         input logic [31:0] e0, input logic [31:0] e1);
        bus.rdReq = 1'b1; bus.rdSel0 = s0; bus.rdSel1 = s1;
        @(negedge clk);
        check("rd_ack", bus.rdAck, 1'b1);
        push_rd(e0, e1);
        step();
        bus.rdReq = 1'b0;
    endtask

    task automatic do_dbg(input logic rdwr_bar, input logic [4:0] sel,
                          input logic [31:0] wdata, input logic [31:0] exp);
        bus.dbgReq = 1'b1; bus.dbgRDWRBar = rdwr_bar; bus.dbgSel = sel; bus.dbgWData = wdata;
        @(negedge clk);
        check("dbg_ack", bus.dbgAck, 1'b1);
        if (rdwr_bar) push_dbg(exp);
        step();
        bus.dbgReq = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_csbar"},   bus.bankCSBar,   1'b1);
        check({tag, "_rdwrbar"}, bus.bankRDWRBar, 1'b1);
        check({tag, "_selsrc0"}, bus.bankSelSrc0, 5'd0);
        check({tag, "_selsrc1"}, bus.bankSelSrc1, 5'd0);
        check({tag, "_seldst"},  bus.bankSelDst,  5'd0);
        check({tag, "_bankdst"}, bus.bankDst,     32'h0);
        check({tag, "_rdvalid"}, bus.rdValid,     1'b0);
        check({tag, "_dbgvalid"},bus.dbgValid,    1'b0);
        check({tag, "_rddata0"}, bus.rdData0,     32'h0);
        check({tag, "_rddata1"}, bus.rdData1,     32'h0);
        check({tag, "_dbgrdata"},bus.dbgRData,    32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.wbReq = 1'b0; bus.wbSel = '0; bus.wbData = '0;
        bus.rdReq = 1'b0; bus.rdSel0 = '0; bus.rdSel1 = '0;
        bus.dbgReq = 1'b0; bus.dbgRDWRBar = 1'b1; bus.dbgSel = '0; bus.dbgWData = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        check("reset_wback", bus.wbAck, 1'b0);
        step();
        resetBar = 1'b1;

        // Write x5 then read (5, 0)
        do_wb(5'd5, 32'hDEAD_BEEF);
        bus.rdReq = 1'b1; bus.rdSel0 = 5'd5; bus.rdSel1 = 5'd0;
        @(negedge clk);
        check("rd_ack", bus.rdAck, 1'b1);
        check("wr_issue_csbar",   bus.bankCSBar,   1'b0);
        check("wr_issue_rdwrbar", bus.bankRDWRBar, 1'b0);
        check("wr_issue_dst",     bus.bankSelDst,  5'd5);
        check("wr_issue_data",    bus.bankDst,     32'hDEAD_BEEF);
        push_rd(32'hDEAD_BEEF, 32'h0);
        step();
        bus.rdReq = 1'b0;
        @(negedge clk);
        check("rd_issue_csbar",   bus.bankCSBar,   1'b0);
        check("rd_issue_rdwrbar", bus.bankRDWRBar, 1'b1);
        check("rd_issue_sel0",    bus.bankSelSrc0, 5'd5);
        check("rd_issue_sel1",    bus.bankSelSrc1, 5'd0);
        step();
        step();
        @(negedge clk);
        check("hold_rdvalid", bus.rdValid, 1'b0);
        check("hold_rddata0", bus.rdData0, 32'hDEAD_BEEF);
        check("hold_rddata1", bus.rdData1, 32'h0);
        step();

        // x0 write is acked but suppressed; reads of x0 return 0
        do_wb(5'd0, 32'h0000_1234);
        @(negedge clk);
        check("x0_wr_csbar", bus.bankCSBar, 1'b1);
        step();
        do_rd(5'd0, 5'd5, 32'h0, 32'hDEAD_BEEF);
        do_dbg(1'b1, 5'd0, 32'h0, 32'h0);
        idle(3);

        // Starvation: writeback held, decode wins on its 5th pending cycle
        bus.wbReq = 1'b1; bus.wbSel = 5'd9; bus.wbData = 32'h1111_0000;
        bus.rdReq = 1'b1; bus.rdSel0 = 5'd9; bus.rdSel1 = 5'd5;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("starve_wback", bus.wbAck, (k != 4));
            check("starve_rdack", bus.rdAck, (k == 4));
            if (k == 4) push_rd(32'h1111_0000, 32'hDEAD_BEEF);
            step();
            if (k == 4) bus.rdReq = 1'b0;
        end
        bus.wbReq = 1'b0;
        idle(3);

        // Leave the pointer on decode, then decode/debug alternate
        do_dbg(1'b1, 5'd3, 32'h0, 32'hBAD0_0003);
        bus.rdReq = 1'b1; bus.rdSel0 = 5'd5; bus.rdSel1 = 5'd9;
        bus.dbgReq = 1'b1; bus.dbgRDWRBar = 1'b1; bus.dbgSel = 5'd3;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rr_rdack",  bus.rdAck,  (k % 2 == 0));
            check("rr_dbgack", bus.dbgAck, (k % 2 == 1));
            if (k % 2 == 0) push_rd(32'hDEAD_BEEF, 32'h1111_0000);
            else            push_dbg(32'hBAD0_0003);
            step();
        end
        bus.rdReq = 1'b0; bus.dbgReq = 1'b0;
        idle(3);

        // Debug write then read of x7
        do_dbg(1'b0, 5'd7, 32'hA5A5_A5A5, 32'h0);
        do_dbg(1'b1, 5'd7, 32'h0, 32'hA5A5_A5A5);
        idle(3);

        // Reset in N+1 flushes a read acked in N
        bus.rdReq = 1'b1; bus.rdSel0 = 5'd5; bus.rdSel1 = 5'd5;
        @(negedge clk);
        check("flush_rdack", bus.rdAck, 1'b1);
        step();
        bus.rdReq = 1'b0;
        resetBar  = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        #1;
        resetBar = 1'b1;
        step();
        @(negedge clk);
        check("flush_no_rdvalid", bus.rdValid, 1'b0);
        step();

        // After reset the round-robin pointer favours decode
        bus.rdReq = 1'b1; bus.rdSel0 = 5'd5; bus.rdSel1 = 5'd7;
        bus.dbgReq = 1'b1; bus.dbgRDWRBar = 1'b1; bus.dbgSel = 5'd7;
        @(negedge clk);
        check("postrst_rdack",  bus.rdAck,  1'b1);
        check("postrst_dbgack", bus.dbgAck, 1'b0);
        push_rd(32'hDEAD_BEEF, 32'hA5A5_A5A5);
        step();
        bus.rdReq = 1'b0;
        @(negedge clk);
        check("postrst_dbgack2", bus.dbgAck, 1'b1);
        push_dbg(32'hA5A5_A5A5);
        step();
        bus.dbgReq = 1'b0;

        // Drain outstanding expectations, bounded
        for (int i = 0; i < 20 && (rd_q.size() != 0 || dbg_q.size() != 0); i++) step();
        check("drain_rd_pending",  32'(rd_q.size()),  32'd0);
        check("drain_dbg_pending", 32'(dbg_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
